// File: rtl/sf_arb_pkg.sv
// Shared types and helpers for the store-and-forward packet arbiter.
package sf_arb_pkg;

  // FLUSH is only reachable when the SF_ARB_WDOG_EN watchdog is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_MAX_PKT_LEN = 256;

  // Width of a port index; never narrower than one bit.
  function automatic int src_width(input int n_ports);
    return (n_ports > 1) ? $clog2(n_ports) : 1;
  endfunction

endpackage

// File: rtl/sf_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching upward and wrapping at N_PORTS. Returns one-hot, index and valid.
module sf_rr_picker
  import sf_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = src_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_PORTS-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  // ptr < N_PORTS and off < N_PORTS, so one conditional subtract wraps.
  function automatic int wrap_add(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= N_PORTS) ? sum - N_PORTS : sum;
  endfunction

  // Walk the ports in priority order starting at ptr; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!gnt_vld && req[wrap_add(int'(ptr), k)]) begin
        gnt_vld                        = 1'b1;
        gnt_oh[wrap_add(int'(ptr), k)] = 1'b1;
        gnt_idx                        = IDX_W'(wrap_add(int'(ptr), k));
      end
    end
  end

endmodule

// File: rtl/sf_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one egress link between N_PORTS
// store-and-forward FIFOs. A port is granted only when it holds a complete
// packet; the packet is then drained word by word through a registered
// valid/ready output stage.
// Optional feature: define SF_ARB_WDOG_EN to compile in the packet-length
// watchdog (truncate at MAX_PKT_LEN words, then flush the rest silently).
module sf_pkt_arbiter
  import sf_arb_pkg::*;
#(
  parameter  int N_PORTS     = 4,
  parameter  int DATA_WIDTH  = 32,
  parameter  int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int SRC_W       = src_width(N_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            pkt_rdy_i,
  output logic [N_PORTS-1:0]            rden_o,
  input  logic [N_PORTS*DATA_WIDTH-1:0] rdata_i,
  input  logic [N_PORTS-1:0]            eop_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          eop_o,
  output logic [SRC_W-1:0]              src_o,
  output logic                          trunc_o,
  output logic                          busy_o
);

  if (N_PORTS < 2 || N_PORTS > 16 || MAX_PKT_LEN < 1) begin : g_bad_cfg
    $error("sf_pkt_arbiter: N_PORTS must be 2..16 and MAX_PKT_LEN >= 1");
  end

  state_t                 state, state_nxt;
  logic [N_PORTS-1:0]     grant_oh;
  logic [SRC_W-1:0]       grant_idx;
  logic [SRC_W-1:0]       rr_ptr;
  logic [N_PORTS-1:0]     pick_oh;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [DATA_WIDTH-1:0]  head_word [N_PORTS];
  logic                   head_eop;
  logic                   pop;
  logic                   load;
  logic                   load_trunc;
  logic                   take_grant;
  logic                   pkt_done;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_head
    assign head_word[i] = rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign head_eop = eop_i[grant_idx];
  assign rden_o   = grant_oh & {N_PORTS{pop}};
  assign busy_o   = (state != IDLE);

  sf_rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (SRC_W)
  ) u_picker (
    .req     (pkt_rdy_i),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

`ifdef SF_ARB_WDOG_EN
  localparam int BEAT_W = $clog2(MAX_PKT_LEN + 1);
  logic [BEAT_W-1:0] beat_cnt;
  logic              trunc_q;

  // Count words popped in XFER; restarts with every new grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        beat_cnt <= '0;
    else if (take_grant)            beat_cnt <= '0;
    else if (pop && state == XFER)  beat_cnt <= beat_cnt + BEAT_W'(1);
  end

  // Truncation flag travels with the word it marks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       trunc_q <= 1'b0;
    else if (load) trunc_q <= load_trunc;
  end

  assign trunc_o = trunc_q;
`else
  assign trunc_o = 1'b0;
`endif

  // Next-state and per-cycle controls; pkt_rdy_i only matters in IDLE.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load       = 1'b0;
    load_trunc = 1'b0;
    take_grant = 1'b0;
    pkt_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          take_grant = 1'b1;
          state_nxt  = XFER;
        end
      end
      XFER: begin
        pop = !valid_o || ready_i;
        if (pop) begin
          load = 1'b1;
          if (head_eop) begin
            pkt_done  = 1'b1;
            state_nxt = IDLE;
          end
`ifdef SF_ARB_WDOG_EN
          else if (beat_cnt == BEAT_W'(MAX_PKT_LEN - 1)) begin
            load_trunc = 1'b1;
            state_nxt  = FLUSH;
          end
`endif
        end
      end
`ifdef SF_ARB_WDOG_EN
      FLUSH: begin
        // Discard the oversize tail regardless of downstream backpressure.
        pop = 1'b1;
        if (head_eop) begin
          pkt_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched grant and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      grant_oh  <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        grant_oh  <= pick_oh;
        grant_idx <= pick_idx;
      end
      if (pkt_done)
        rr_ptr <= (grant_idx == SRC_W'(N_PORTS - 1)) ? '0 : grant_idx + SRC_W'(1);
    end
  end

  // Output register: load on pop, empty on accept, otherwise hold steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      eop_o   <= 1'b0;
      src_o   <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= head_word[grant_idx];
      eop_o   <= head_eop | load_trunc;
      src_o   <= grant_idx;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sf_pkt_arbiter.sv
// Directed bench for sf_pkt_arbiter (and its sf_rr_picker). Upstream FIFOs
// are modelled as per-port word arrays; accepted output words are logged
// with their cycle number and compared against hand-computed expectations.
module tb_sf_pkt_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXL = 4;
  localparam int SW   = 2;
`ifdef SF_ARB_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    pkt_rdy_i = '0;
  logic [N-1:0]    rden_o;
  logic [N*DW-1:0] rdata_i = '0;
  logic [N-1:0]    eop_i = '0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [DW-1:0]   data_o;
  logic            eop_o;
  logic [SW-1:0]   src_o;
  logic            trunc_o;
  logic            busy_o;

  always #5 clk = ~clk;

  sf_pkt_arbiter #(
    .N_PORTS     (N),
    .DATA_WIDTH  (DW),
    .MAX_PKT_LEN (MAXL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_rdy_i (pkt_rdy_i),
    .rden_o    (rden_o),
    .rdata_i   (rdata_i),
    .eop_i     (eop_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .eop_o     (eop_o),
    .src_o     (src_o),
    .trunc_o   (trunc_o),
    .busy_o    (busy_o)
  );

  // Stand-alone picker instance for the table-driven unit vectors.
  logic [3:0] pk_req = '0;
  logic [1:0] pk_ptr = '0;
  logic [3:0] pk_oh;
  logic [1:0] pk_idx;
  logic       pk_vld;

  sf_rr_picker #(.N_PORTS(4)) u_pick (
    .req     (pk_req),
    .ptr     (pk_ptr),
    .gnt_oh  (pk_oh),
    .gnt_idx (pk_idx),
    .gnt_vld (pk_vld)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- upstream FIFO model ----------------
  logic [DW-1:0] f_data [N][64];
  logic          f_eop  [N][64];
  int            wr_ptr [N];
  int            rd_ptr [N];
  logic [N-1:0]  snap = '0;

  function automatic logic has_pkt(input int p);
    for (int k = rd_ptr[p]; k < wr_ptr[p]; k++)
      if (f_eop[p][k]) return 1'b1;
    return 1'b0;
  endfunction

  // A pop seen in one cycle is retired at the next falling edge, after the
  // DUT has consumed the head word on the rising edge in between.
  initial begin
    for (int i = 0; i < N; i++) rd_ptr[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) rd_ptr[i] = 0;
        snap = '0;
      end else begin
        for (int i = 0; i < N; i++)
          if (snap[i] && rd_ptr[i] < wr_ptr[i]) rd_ptr[i] = rd_ptr[i] + 1;
        snap = rden_o;
      end
      for (int i = 0; i < N; i++) begin
        pkt_rdy_i[i] = has_pkt(i);
        if (rd_ptr[i] < wr_ptr[i]) begin
          rdata_i[i*DW +: DW] = f_data[i][rd_ptr[i]];
          eop_i[i]            = f_eop[i][rd_ptr[i]];
        end else begin
          rdata_i[i*DW +: DW] = '0;
          eop_i[i]            = 1'b0;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [DW-1:0] lg_data  [256];
  logic          lg_eop   [256];
  logic          lg_trunc [256];
  logic [SW-1:0] lg_src   [256];
  int            lg_cyc   [256];
  int            lg_n = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && valid_o && ready_i && lg_n < 256) begin
        lg_data[lg_n]  = data_o;
        lg_eop[lg_n]   = eop_o;
        lg_trunc[lg_n] = trunc_o;
        lg_src[lg_n]   = src_o;
        lg_cyc[lg_n]   = cyc;
        lg_n           = lg_n + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [DW-1:0] wd(input int p, input int k, input int w);
    return {8'(p), 8'hC5, 8'(k), 8'(w)};
  endfunction

  task automatic push(input int p, input int k, input int len);
    for (int w = 0; w < len; w++) begin
      f_data[p][wr_ptr[p]] = wd(p, k, w);
      f_eop[p][wr_ptr[p]]  = (w == len - 1);
      wr_ptr[p]            = wr_ptr[p] + 1;
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    ready_i = 1'b1;
    for (int i = 0; i < N; i++) wr_ptr[i] = 0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic check_beat(input string name, input int idx, input logic [DW-1:0] d,
                            input logic e, input int s, input logic t,
                            input int rel, input int c0);
    check($sformatf("%s_b%0d_word", name, idx),
          {lg_data[idx], lg_eop[idx], lg_src[idx], lg_trunc[idx]},
          {d, e, SW'(s), t});
    check($sformatf("%s_b%0d_cyc", name, idx), 64'(lg_cyc[idx] - c0), 64'(rel));
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic [3:0] oh;
    logic [1:0] idx;
    logic       vld;
  } pick_vec_t;

  pick_vec_t pv [9];

  // Hard stop in case something wedges the scheduler.
  initial begin
    #200000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, c0, c1, n1;

    // ---- picker unit vectors: req, ptr -> one-hot, index, valid ----
    pv[0] = '{4'b0000, 2'd0, 4'b0000, 2'd0, 1'b0};
    pv[1] = '{4'b0001, 2'd0, 4'b0001, 2'd0, 1'b1};
    pv[2] = '{4'b1111, 2'd0, 4'b0001, 2'd0, 1'b1};
    pv[3] = '{4'b1111, 2'd2, 4'b0100, 2'd2, 1'b1};
    pv[4] = '{4'b0011, 2'd2, 4'b0001, 2'd0, 1'b1};
    pv[5] = '{4'b1000, 2'd3, 4'b1000, 2'd3, 1'b1};
    pv[6] = '{4'b0110, 2'd3, 4'b0010, 2'd1, 1'b1};
    pv[7] = '{4'b1010, 2'd1, 4'b0010, 2'd1, 1'b1};
    pv[8] = '{4'b1010, 2'd2, 4'b1000, 2'd3, 1'b1};
    for (int i = 0; i < 9; i++) begin
      pk_req = pv[i].req;
      pk_ptr = pv[i].ptr;
      #1;
      check($sformatf("pick%0d", i), {pk_oh, pk_idx, pk_vld}, {pv[i].oh, pv[i].idx, pv[i].vld});
    end

    // ---- reset values ----
    for (int i = 0; i < N; i++) wr_ptr[i] = 0;
    ticks(2);
    check("reset_outs", {valid_o, eop_o, trunc_o, busy_o, rden_o, data_o, src_o}, 64'd0);
    rst = 1'b0;
    tick();

    // ---- 3-word packet on port 0 ----
    do_reset();
    base = lg_n; c0 = cyc;
    push(0, 1, 3);
    tick();
    check("t1_rden_first", {busy_o, rden_o}, {1'b1, 4'b0001});
    ticks(3);
    check("t1_busy_after_last", {busy_o, rden_o}, {1'b0, 4'b0000});
    tick();
    check("t1_valid_cleared", valid_o, 1'b0);
    check("t1_count", lg_n - base, 3);
    for (int w = 0; w < 3; w++)
      check_beat("t1", base + w, wd(0, 1, w), w == 2, 0, 1'b0, 2 + w, c0);

    // ---- all four ports, one 2-word packet each ----
    do_reset();
    base = lg_n; c0 = cyc;
    for (int p = 0; p < N; p++) push(p, 2, 2);
    ticks(14);
    check("t2_count", lg_n - base, 8);
    for (int j = 0; j < 8; j++)
      check_beat("t2", base + j, wd(j / 2, 2, j % 2), (j % 2) == 1, j / 2, 1'b0,
                 2 + 3 * (j / 2) + (j % 2), c0);

    // ---- backpressure 1,0,0,1 during a 4-word packet on port 1 ----
    do_reset();
    base = lg_n; c0 = cyc;
    push(1, 3, 4);
    ticks(3);
    ready_i = 1'b0;
    #1;
    check("t3_stall1", {valid_o, rden_o, data_o}, {1'b1, 4'b0000, wd(1, 3, 1)});
    tick();
    check("t3_stall2", {valid_o, rden_o, data_o}, {1'b1, 4'b0000, wd(1, 3, 1)});
    tick();
    ready_i = 1'b1;
    ticks(4);
    check("t3_count", lg_n - base, 4);
    check_beat("t3", base + 0, wd(1, 3, 0), 1'b0, 1, 1'b0, 2, c0);
    check_beat("t3", base + 1, wd(1, 3, 1), 1'b0, 1, 1'b0, 5, c0);
    check_beat("t3", base + 2, wd(1, 3, 2), 1'b0, 1, 1'b0, 6, c0);
    check_beat("t3", base + 3, wd(1, 3, 3), 1'b1, 1, 1'b0, 7, c0);

    // ---- port 2 sole requester, two 1-word packets ----
    do_reset();
    base = lg_n; c0 = cyc;
    push(2, 4, 1);
    push(2, 5, 1);
    ticks(6);
    check("t4_count", lg_n - base, 2);
    check_beat("t4", base + 0, wd(2, 4, 0), 1'b1, 2, 1'b0, 2, c0);
    check_beat("t4", base + 1, wd(2, 5, 0), 1'b1, 2, 1'b0, 4, c0);

    // ---- 7-word packet on port 1 (watchdog at 4 words), then port 2 ----
    do_reset();
    base = lg_n; c0 = cyc;
    push(1, 6, 7);
    push(2, 7, 2);
    ticks(13);
    n1 = WDOG_ON ? MAXL : 7;
    check("t5_count", lg_n - base, n1 + 2);
    for (int w = 0; w < n1; w++)
      check_beat("t5", base + w, wd(1, 6, w), w == n1 - 1, 1,
                 WDOG_ON && (w == n1 - 1), 2 + w, c0);
    check_beat("t5", base + n1,     wd(2, 7, 0), 1'b0, 2, 1'b0, 10, c0);
    check_beat("t5", base + n1 + 1, wd(2, 7, 1), 1'b1, 2, 1'b0, 11, c0);
    check("t5_port1_drained", rd_ptr[1], 7);

    // ---- reset during word 2 of a 5-word packet ----
    do_reset();
    base = lg_n; c0 = cyc;
    push(0, 8, 5);
    ticks(3);
    rst = 1'b1;
    for (int i = 0; i < N; i++) wr_ptr[i] = 0;
    #1;
    check("t6_reset_outs", {valid_o, eop_o, trunc_o, busy_o, rden_o, data_o, src_o}, 64'd0);
    ticks(2);
    rst = 1'b0;
    tick();
    check("t6_pre_count", lg_n - base, 1);
    check_beat("t6", base, wd(0, 8, 0), 1'b0, 0, 1'b0, 2, c0);
    base = lg_n; c1 = cyc;
    push(3, 9, 2);
    ticks(5);
    check("t6_post_count", lg_n - base, 2);
    check_beat("t6post", base + 0, wd(3, 9, 0), 1'b0, 3, 1'b0, 2, c1);
    check_beat("t6post", base + 1, wd(3, 9, 1), 1'b1, 3, 1'b0, 3, c1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sf_pkt_arbiter.md
# sf_pkt_arbiter

Packet-level round-robin arbiter that shares one downstream link between `N_PORTS` store-and-forward FIFOs. It grants a FIFO only when that FIFO holds a complete packet, then drains the packet word by word until end-of-packet. It presents the words on a registered valid/ready output. It sits between the per-port `sf_FIFO` instances (with their eop/error checkers) and the egress datapath.

## Interface
- `N_PORTS`, 4: number of upstream FIFOs (2..16).
- `DATA_WIDTH`, 32: word width.
- `MAX_PKT_LEN`, 256: longest legal packet in words. Used only when the watchdog is compiled in.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pkt_rdy_i` input N_PORTS: bit i set means FIFO i holds at least one complete packet.
- `rden_o` output N_PORTS: one-hot pop to the granted FIFO; all zero otherwise.
- `rdata_i` input N_PORTS*DATA_WIDTH: show-ahead head words; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `eop_i` input N_PORTS: last-word flag of each head word.
- `valid_o` output 1: output register holds a word.
- `ready_i` input 1: downstream accepts the word when valid_o && ready_i.
- `data_o` output DATA_WIDTH: registered word.
- `eop_o` output 1: registered last-word flag.
- `src_o` output $clog2(N_PORTS): source port of data_o.
- `trunc_o` output 1: set together with eop_o on a watchdog-truncated packet. Tied 0 without the macro.
- `busy_o` output 1: state != IDLE.

## Operation
- States: IDLE, XFER, FLUSH. FLUSH exists only with the watchdog macro.
- IDLE:
  - If pkt_rdy_i != 0, grant the first set bit at or after rr_ptr, searching upward and wrapping.
  - Latch the grant and go to XFER.
  - Otherwise stay in IDLE.
  - pkt_rdy_i is sampled only in IDLE.
- XFER:
  - pop = (!valid_o || ready_i). rden_o[grant] = pop.
  - On a pop, the output register loads rdata_i[grant], eop_i[grant] and grant.
  - If the popped word has eop_i set: next state IDLE; rr_ptr <= (grant+1) mod N_PORTS.
- Output register:
  - Cleared to valid_o=0 when downstream accepts a word and no word is loaded that cycle.
  - Otherwise it holds its contents, which must stay stable while valid_o && !ready_i.
- One idle bubble per packet: the IDLE cycle issues no pop.
- Width rules:
  - Beat counter is $clog2(MAX_PKT_LEN+1) bits and clears on every grant.
  - rr_ptr wraps at N_PORTS, not at a power of two.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0, beat counter 0.
  - valid_o 0, eop_o 0, trunc_o 0, busy_o 0, rden_o 0.
  - data_o 0, src_o 0.
- Latency:
  - pkt_rdy_i seen in IDLE at cycle k: rden_o high at k+1; valid_o high with the first word at k+2.
  - Throughput is one word per cycle while ready_i stays high.
- Single-word packet: one pop in XFER, then back in IDLE. Next grant possible 1 cycle later.
- ready_i low: rden_o stays 0 once the register is full; no word is lost or duplicated.
- Same port is the only requester: it is re-granted after one IDLE cycle, because the wrap search returns to it.
- A granted port deasserting pkt_rdy_i during XFER is ignored. A complete packet is guaranteed by the FIFO.
- rst asserted mid-packet: all state clears immediately and the partial packet is abandoned. Upstream FIFOs are reset by the same rst.

## Configuration
- `SF_ARB_WDOG_EN` defined:
  - If the MAX_PKT_LEN-th word is popped without eop_i, the register loads it with eop_o=1 and trunc_o=1.
  - State moves to FLUSH.
  - FLUSH pops the granted FIFO every cycle, regardless of ready_i, discarding words until a popped word has eop_i. Then IDLE, with rr_ptr advanced.
  - valid_o is not asserted for discarded words.
- `SF_ARB_WDOG_EN` undefined: no beat counter and no FLUSH state; trunc_o is constant 0.

## Structure
- Package `sf_arb_pkg`:
  - `state_t` enum (IDLE, XFER, FLUSH).
  - Localparam for the default MAX_PKT_LEN.
  - Function computing the src width.
- Sub-module `sf_rr_picker`: combinational wrap-around first-set search (req, ptr → one-hot grant and index). Unit-tested separately.

## Test plan
- Reset, then pkt_rdy_i=0001 with a 3-word packet on port 0 (eop on word 3), ready_i=1 → valid_o high cycles 2-4 with src_o=0, eop_o only on word 3; busy_o drops after the last pop.
- pkt_rdy_i=1111, each port holding one 2-word packet → grant order 0,1,2,3, with one bubble between packets.
- ready_i toggling 1,0,0,1 during a 4-word packet → data_o held stable while stalled; rden_o low during the stall; exactly 4 words delivered in order.
- Port 2 is the sole requester with two back-to-back 1-word packets → both from src_o=2, 2 cycles apart.
- Watchdog on, MAX_PKT_LEN=4, 7-word packet on port 1 → 4 words out, the 4th with eop_o=1 and trunc_o=1; 3 words popped silently; next packet on port 2 follows.
- rst pulsed during word 2 of a 5-word packet → all outputs at reset values the same cycle; normal arbitration resumes after release.
